// File: rtl/sync_debounce_edge.sv
// Debounces an already-synchronized level and emits one-cycle rise/fall pulses
// on accepted transitions, plus a wrapping count of accepted rising edges.
module sync_debounce_edge #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_sig_i,
  input  logic             clear_i,
  output logic             level_o,
  output logic             rise_pulse_o,
  output logic             fall_pulse_o,
  output logic [CNT_W-1:0] edge_count_o
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  // cnt_q holds how many consecutive new-level samples have been seen so far.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (sync_sig_i) begin
          state_d = S_RISE;
          cnt_d   = CW'(1);
        end
      end
      S_RISE: begin
        if (!sync_sig_i) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (!sync_sig_i) begin
          state_d = S_FALL;
          cnt_d   = CW'(1);
        end
      end
      S_FALL: begin
        if (sync_sig_i) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear takes effect before an increment accepted on the same edge.
  always_comb begin
    count_d = clear_i ? '0 : count_q;
    if (rise_d) begin
      count_d = count_d + CNT_W'(1);
    end
  end

  assign level_o      = level_q;
  assign rise_pulse_o = rise_q;
  assign fall_pulse_o = fall_q;
  assign edge_count_o = count_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed self-checking bench for sync_debounce_edge, including a
// three-flop synchronizer in front of the DUT for the chained scenario.
module tb_sync_debounce_edge;

  logic       clk = 1'b0;
  logic       rst;
  logic       drvSig;
  logic       clearIn;
  logic       chainMode;
  logic       asyncIn;
  logic [2:0] syncChain;
  logic       syncSig;
  logic       levelOut;
  logic       riseOut;
  logic       fallOut;
  logic [7:0] countOut;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) syncChain <= {syncChain[1:0], asyncIn};

  assign syncSig = chainMode ? syncChain[2] : drvSig;

  sync_debounce_edge #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sync_sig_i   (syncSig),
    .clear_i      (clearIn),
    .level_o      (levelOut),
    .rise_pulse_o (riseOut),
    .fall_pulse_o (fallOut),
    .edge_count_o (countOut)
  );

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic lvl, input logic rise,
                             input logic fall, input logic [7:0] cnt);
    checkOne({tag, ".level"}, {31'd0, levelOut}, {31'd0, lvl});
    checkOne({tag, ".rise"},  {31'd0, riseOut},  {31'd0, rise});
    checkOne({tag, ".fall"},  {31'd0, fallOut},  {31'd0, fall});
    checkOne({tag, ".count"}, {24'd0, countOut}, {24'd0, cnt});
  endtask

  // Drive on the falling edge, then sample 1 ns after the next rising edge.
  task automatic applyStimulus(input logic sig, input logic clr);
    @(negedge clk);
    drvSig  = sig;
    clearIn = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    drvSig    = 1'b1;
    clearIn   = 1'b0;
    chainMode = 1'b0;
    asyncIn   = 1'b0;

    #3;
    checkOutput("resetAsync", 0, 0, 0, 8'd0);
    @(negedge clk);
    rst    = 1'b0;
    drvSig = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0);
      checkOutput("resetHold", 0, 0, 0, 8'd0);
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0);
      checkOutput("riseWait", 0, 0, 0, 8'd0);
    end
    applyStimulus(1, 0);
    checkOutput("riseAccept", 1, 1, 0, 8'd1);
    applyStimulus(1, 0);
    checkOutput("riseAfter", 1, 0, 0, 8'd1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0);
      checkOutput("glitchHigh", 1, 0, 0, 8'd1);
    end
    applyStimulus(1, 0);
    checkOutput("glitchHighEnd", 1, 0, 0, 8'd1);
    applyStimulus(1, 0);
    checkOutput("glitchHighHold", 1, 0, 0, 8'd1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0);
      checkOutput("fallWait", 1, 0, 0, 8'd1);
    end
    applyStimulus(0, 0);
    checkOutput("fallAccept", 0, 0, 1, 8'd1);
    applyStimulus(0, 0);
    checkOutput("fallAfter", 0, 0, 0, 8'd1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0);
      checkOutput("glitchLow", 0, 0, 0, 8'd1);
    end
    applyStimulus(0, 0);
    checkOutput("glitchLowEnd", 0, 0, 0, 8'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0);
      checkOutput("restartWait", 0, 0, 0, 8'd1);
    end
    applyStimulus(1, 0);
    checkOutput("restartAccept", 1, 1, 0, 8'd2);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0);
    checkOutput("restartFall", 0, 0, 1, 8'd2);

    applyStimulus(0, 1);
    checkOutput("clearBeforeWrap", 0, 0, 0, 8'd0);
    for (int p = 0; p < 255; p++) begin
      for (int i = 0; i < 4; i++) applyStimulus(1, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0);
    end
    checkOne("wrapPre.count", {24'd0, countOut}, 32'd255);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0);
    checkOutput("wrapAccept", 1, 1, 0, 8'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0);
    checkOutput("wrapFall", 0, 0, 1, 8'd0);

    for (int i = 0; i < 4; i++) applyStimulus(1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0);
    checkOutput("preClear", 0, 0, 1, 8'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0);
    applyStimulus(1, 1);
    checkOutput("clearWithRise", 1, 1, 0, 8'd1);
    applyStimulus(1, 0);
    checkOutput("clearWithRiseAfter", 1, 0, 0, 8'd1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0);
    checkOutput("clearFall", 0, 0, 1, 8'd1);

    for (int i = 0; i < 3; i++) applyStimulus(1, 0);
    checkOutput("partialRise", 0, 0, 0, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midReset", 0, 0, 0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postReset1", 0, 0, 0, 8'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0);
      checkOutput("postResetWait", 0, 0, 0, 8'd0);
    end
    applyStimulus(1, 0);
    checkOutput("postResetAccept", 1, 1, 0, 8'd1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0);
    checkOutput("postResetFall", 0, 0, 1, 8'd1);

    applyStimulus(0, 1);
    checkOutput("clearAlone", 0, 0, 0, 8'd0);
    applyStimulus(0, 0);
    checkOutput("clearAloneAfter", 0, 0, 0, 8'd0);

    @(negedge clk);
    chainMode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #3;
      checkOutput("chainToggle", 0, 0, 0, 8'd0);
      if (i % 2 == 0) asyncIn = ~asyncIn;
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #3;
      checkOutput("chainSettle", 0, 0, 0, 8'd0);
    end
    asyncIn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      checkOutput("chainRise", (k >= 7), (k == 7), 1'b0, (k >= 7) ? 8'd1 : 8'd0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
